// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// values, datapath select codes and the one-hot instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // IR[5:0] for R-type
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Immediate extender control
  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;
  localparam logic [1:0] EOP_SHL2 = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_PASB = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_EXT = 2'b10;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;

  // One-hot instruction class; exactly one field set at a time
  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic none;
  } icls_t;

  // Immediate extender; the datapath uses this so it shares EOp codes with
  // the controller.
  function automatic logic [31:0] ext_imm(input logic [1:0] eop,
                                          input logic [15:0] imm);
    logic [31:0] r;
    case (eop)
      EOP_SIGN: r = {{16{imm[15]}}, imm};
      EOP_ZERO: r = {16'h0000, imm};
      EOP_LUI:  r = {imm, 16'h0000};
      default:  r = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Maps op/funct to a one-hot instruction class; anything unrecognised
// (including the all-zero nop) lands in the none class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output icls_t      cls
);

  // Class lookup; none is the complement of every supported class
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        cls.rtype_add = (funct == FN_ADDU);
        cls.rtype_sub = (funct == FN_SUBU);
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_J:    cls.j   = 1'b1;
      default: ;
    endcase
    cls.none = ~(cls.rtype_add | cls.rtype_sub | cls.ori | cls.lw |
                 cls.sw | cls.beq | cls.lui | cls.j);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: state register plus combinational
// control outputs derived from state, decoded instruction, zero and mem_rdy.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic [1:0] alu_srcb,
  output logic [1:0] alu_op,
  output logic [1:0] EOp,
  output logic [2:0] state
);

  state_e state_q, nxt;
  icls_t  cls;

  mc_decode u_dec (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  assign state = state_q;

  // Next state and control outputs; reset masks writes but keeps the
  // memory pointed at the PC so the first fetch address is already stable.
  always_comb begin
    nxt      = state_q;
    pc_wr    = 1'b0;
    pc_src   = PC_PLUS4;
    ir_wr    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    iord     = 1'b0;
    reg_wr   = 1'b0;
    reg_dst  = 1'b0;
    mem2reg  = 1'b0;
    alu_srcb = SRCB_RT;
    alu_op   = ALU_ADD;
    EOp      = EOP_SIGN;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target precomputed here so EXEC only needs the compare
        EOp      = EOP_SHL2;
        alu_srcb = SRCB_EXT;
        alu_op   = ALU_ADD;
        if (cls.j) begin
          pc_wr  = 1'b1;
          pc_src = PC_JUMP;
          nxt    = S_FETCH;
        end else if (cls.none) begin
          nxt = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        nxt = S_FETCH;
        if (cls.rtype_add || cls.rtype_sub) begin
          alu_op = cls.rtype_sub ? ALU_SUB : ALU_ADD;
          nxt    = S_WB;
        end else if (cls.ori) begin
          EOp      = EOP_ZERO;
          alu_srcb = SRCB_EXT;
          alu_op   = ALU_OR;
          nxt      = S_WB;
        end else if (cls.lui) begin
          EOp      = EOP_LUI;
          alu_srcb = SRCB_EXT;
          alu_op   = ALU_PASB;
          nxt      = S_WB;
        end else if (cls.lw || cls.sw) begin
          EOp      = EOP_SIGN;
          alu_srcb = SRCB_EXT;
          nxt      = S_MEM;
        end else if (cls.beq) begin
          alu_op = ALU_SUB;
          pc_src = PC_BR;
          pc_wr  = zero;
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        mem_rd = cls.lw;
        mem_wr = cls.sw;
        if (mem_rdy) nxt = cls.lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = cls.rtype_add | cls.rtype_sub;
        mem2reg = cls.lw;
        nxt     = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    if (!reset_n) begin
      pc_wr    = 1'b0;
      pc_src   = PC_PLUS4;
      ir_wr    = 1'b0;
      mem_rd   = 1'b1;
      mem_wr   = 1'b0;
      iord     = 1'b0;
      reg_wr   = 1'b0;
      reg_dst  = 1'b0;
      mem2reg  = 1'b0;
      alu_srcb = SRCB_RT;
      alu_op   = ALU_ADD;
      EOp      = EOP_SIGN;
    end
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= nxt;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed cycle-by-cycle bench for mc_ctrl with hand-computed output vectors.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_rdy;
  logic       pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, reg_dst, mem2reg;
  logic [1:0] pc_src, alu_srcb, alu_op, EOp;
  logic [2:0] state;
  logic [15:0] outs;
  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_rdy(mem_rdy), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .EOp(EOp), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {pc_wr, pc_src, ir_wr, mem_rd, mem_wr, iord, reg_wr,
                 reg_dst, mem2reg, alu_srcb, alu_op, EOp};

  // Expected output vector in the same field order as outs
  function automatic logic [15:0] o(logic pcw, logic [1:0] pcs, logic irw,
      logic mrd, logic mwr, logic ia, logic rw, logic rd, logic m2r,
      logic [1:0] sb, logic [1:0] aop, logic [1:0] eop);
    return {pcw, pcs, irw, mrd, mwr, ia, rw, rd, m2r, sb, aop, eop};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check mid-cycle, then advance one clock
  task automatic cyc(string tag, logic [2:0] st, logic [15:0] ov);
    #4;
    chk({tag, "_st"}, {13'd0, state}, {13'd0, st});
    chk({tag, "_o"}, outs, ov);
    chk({tag, "_x"}, {15'd0, mem_rd & mem_wr}, 16'd0);
    @(posedge clk); #1;
  endtask

  logic [15:0] F_RDY, F_WAIT, D_STD, D_J, E_ADD, E_SUB, E_ORI, E_LUI, E_LS;
  logic [15:0] E_BEQ1, E_BEQ0, M_LW, M_SW, W_R, W_LW, W_I;

  initial begin
    F_RDY  = o(1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    F_WAIT = o(0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    D_STD  = o(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd3);
    D_J    = o(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd3);
    E_ADD  = o(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    E_SUB  = o(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0);
    E_ORI  = o(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd1);
    E_LUI  = o(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd3, 2'd2);
    E_LS   = o(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0);
    E_BEQ1 = o(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0);
    E_BEQ0 = o(0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0);
    M_LW   = o(0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    M_SW   = o(0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    W_R    = o(0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);
    W_LW   = o(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0);
    W_I    = o(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0);

    // Reset with mem_rdy high: write enables masked, FETCH-style outputs
    reset_n = 1'b0; op = 6'h00; funct = 6'h21; zero = 1'b0; mem_rdy = 1'b1;
    @(posedge clk); #1;
    cyc("rst", 3'd0, F_WAIT);
    reset_n = 1'b1; mem_rdy = 1'b0;
    cyc("rel_wait", 3'd0, F_WAIT);

    // addu: 0,1,2,4
    mem_rdy = 1'b1;
    cyc("add_f", 3'd0, F_RDY);
    cyc("add_d", 3'd1, D_STD);
    cyc("add_e", 3'd2, E_ADD);
    cyc("add_w", 3'd4, W_R);

    // lw with two MEM wait cycles: 7 cycles total
    op = 6'h23; funct = 6'h00;
    cyc("lw_f", 3'd0, F_RDY);
    cyc("lw_d", 3'd1, D_STD);
    cyc("lw_e", 3'd2, E_LS);
    mem_rdy = 1'b0;
    cyc("lw_m0", 3'd3, M_LW);
    cyc("lw_m1", 3'd3, M_LW);
    mem_rdy = 1'b1;
    cyc("lw_m2", 3'd3, M_LW);
    cyc("lw_w", 3'd4, W_LW);

    // beq taken, then not taken
    op = 6'h04; zero = 1'b1;
    cyc("beq1_f", 3'd0, F_RDY);
    cyc("beq1_d", 3'd1, D_STD);
    cyc("beq1_e", 3'd2, E_BEQ1);
    zero = 1'b0;
    cyc("beq0_f", 3'd0, F_RDY);
    cyc("beq0_d", 3'd1, D_STD);
    cyc("beq0_e", 3'd2, E_BEQ0);

    // ori, lui
    op = 6'h0D;
    cyc("ori_f", 3'd0, F_RDY);
    cyc("ori_d", 3'd1, D_STD);
    cyc("ori_e", 3'd2, E_ORI);
    cyc("ori_w", 3'd4, W_I);
    op = 6'h0F;
    cyc("lui_f", 3'd0, F_RDY);
    cyc("lui_d", 3'd1, D_STD);
    cyc("lui_e", 3'd2, E_LUI);
    cyc("lui_w", 3'd4, W_I);

    // subu
    op = 6'h00; funct = 6'h23;
    cyc("sub_f", 3'd0, F_RDY);
    cyc("sub_d", 3'd1, D_STD);
    cyc("sub_e", 3'd2, E_SUB);
    cyc("sub_w", 3'd4, W_R);

    // j: two cycles
    op = 6'h02; funct = 6'h00;
    cyc("j_f", 3'd0, F_RDY);
    cyc("j_d", 3'd1, D_J);

    // nop (all zero) retires through DECODE
    op = 6'h00;
    cyc("nop_f", 3'd0, F_RDY);
    cyc("nop_d", 3'd1, D_STD);

    // sw, reset asserted during MEM wait
    op = 6'h2B;
    cyc("sw_f", 3'd0, F_RDY);
    cyc("sw_d", 3'd1, D_STD);
    cyc("sw_e", 3'd2, E_LS);
    mem_rdy = 1'b0;
    cyc("sw_m0", 3'd3, M_SW);
    reset_n = 1'b0;
    cyc("sw_rst", 3'd3, F_WAIT);
    reset_n = 1'b1;
    cyc("sw_after", 3'd0, F_WAIT);

    // full sw with no wait: 4 cycles
    mem_rdy = 1'b1;
    cyc("sw2_f", 3'd0, F_RDY);
    cyc("sw2_d", 3'd1, D_STD);
    cyc("sw2_e", 3'd2, E_LS);
    cyc("sw2_m", 3'd3, M_SW);

    // unsupported op 0x3F: DECODE then FETCH
    op = 6'h3F;
    cyc("bad_f", 3'd0, F_RDY);
    cyc("bad_d", 3'd1, D_STD);
    mem_rdy = 1'b0;
    cyc("bad_back", 3'd0, F_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
